// File: rtl/mem_port_arbiter.sv
// Arbitrates NCORE pipelined cores onto one fixed-latency data-memory port.
// Define ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration; default is round-robin.
module mem_port_arbiter #(
    parameter int NCORE   = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NCORE-1:0]    req_i,
    input  logic [NCORE-1:0]    we_i,
    input  logic [NCORE*AW-1:0] addr_i,
    input  logic [NCORE*DW-1:0] wdata_i,
    output logic [NCORE-1:0]    gnt_o,
    output logic [NCORE-1:0]    done_o,
    output logic [DW-1:0]       rdata_o,
    output logic [NCORE-1:0]    stall_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [AW-1:0]       mem_addr_o,
    output logic [DW-1:0]       mem_wdata_o,
    input  logic [DW-1:0]       mem_rdata_i
);

    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;
    localparam int CW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [NCORE-1:0] owner;
    logic [IW-1:0]    win;
    logic             any_req;

    assign any_req = |req_i;

`ifdef ARB_FIXED_PRIORITY_EN
    always_comb begin
        win = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (req_i[i]) win = IW'(i);
        end
    end
`else
    logic [IW-1:0] last;
    logic          found;

    // Circular search beginning just after the previous winner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= NCORE; i++) begin
            if (!found && req_i[(int'(last) + i) % NCORE]) begin
                found = 1'b1;
                win   = IW'((int'(last) + i) % NCORE);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last <= IW'(NCORE - 1);
        end else if (state == IDLE && any_req) begin
            last <= win;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        gnt_o     = '0;
        done_o    = '0;
        mem_en_o  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = BUSY;
            end
            BUSY: begin
                gnt_o    = owner;
                mem_en_o = 1'b1;
                if (cnt == CW'(MEM_LAT - 1)) state_nxt = DONE;
            end
            DONE: begin
                done_o    = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_o = req_i & ~done_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= '0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rdata_o     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner       <= NCORE'(1) << win;
                        mem_we_o    <= we_i[win];
                        mem_addr_o  <= addr_i[int'(win)*AW +: AW];
                        mem_wdata_o <= wdata_i[int'(win)*DW +: DW];
                        cnt         <= '0;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // Memory data is valid only in the final BUSY cycle.
                    if (state_nxt == DONE) rdata_o <= mem_rdata_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by random
// per-core agents, checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

    localparam int NCORE   = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MEM_LAT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NCORE-1:0]    req, we;
    logic [NCORE*AW-1:0] addr;
    logic [NCORE*DW-1:0] wdata;
    logic [NCORE-1:0]    gnt, done, stall;
    logic [DW-1:0]       rdata, mem_rdata, mem_wdata;
    logic                mem_en, mem_we;
    logic [AW-1:0]       mem_addr;

    mem_port_arbiter #(.NCORE(NCORE), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .done_o(done), .rdata_o(rdata), .stall_o(stall), .mem_en_o(mem_en),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memfn(input logic [AW-1:0] a);
        if (a == AW'(32'h10)) return DW'(32'hCAFE);
        return DW'((a * 32'h9E3779B1) ^ 32'h1234_5678);
    endfunction

    assign mem_rdata = memfn(mem_addr);

    typedef struct {
        int              core;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
        logic [DW-1:0]   rdata;
        int              start;
    } exp_t;

    exp_t          q[$];
    int            cyc = 0;
    int            next_free = 0;
    int            last = NCORE - 1;
    logic [DW-1:0] hold = '0;
    int            n_cmp = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Chooses the next owner from the requesting set as the arbitration rule describes.
    function automatic int pick(input logic [NCORE-1:0] r, input int prev);
        int c;
        c = -1;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < NCORE; k++) if (c < 0 && r[k]) c = k;
`else
        for (int s = 1; s <= NCORE; s++) if (c < 0 && r[(prev + s) % NCORE]) c = (prev + s) % NCORE;
`endif
        return c;
    endfunction

    task automatic model_and_monitor();
        exp_t             e;
        logic [NCORE-1:0] exp_gnt, exp_done;
        logic             exp_en;
        int               c;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                next_free = cyc + 1;
                last      = NCORE - 1;
                hold      = '0;
            end else if (cyc >= next_free && |req) begin
                c = pick(req, last);
                e.core  = c;
                e.we    = we[c];
                e.addr  = addr[c*AW +: AW];
                e.wdata = wdata[c*DW +: DW];
                e.rdata = memfn(e.addr);
                e.start = cyc;
                q.push_back(e);
                last      = c;
                next_free = cyc + MEM_LAT + 2;
            end
            cyc++;
            @(negedge clk);
            if (chk_en) begin
                exp_gnt  = '0;
                exp_done = '0;
                exp_en   = 1'b0;
                if (q.size() > 0) begin
                    e = q[0];
                    if (cyc > e.start && cyc <= e.start + MEM_LAT) begin
                        exp_gnt = NCORE'(1) << e.core;
                        exp_en  = 1'b1;
                        chk("mem_we", 64'(mem_we), 64'(e.we));
                        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                        chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                    if (cyc == e.start + MEM_LAT + 1) begin
                        exp_done = NCORE'(1) << e.core;
                        hold     = e.rdata;
                        void'(q.pop_front());
                    end
                end
                chk("gnt", 64'(gnt), 64'(exp_gnt));
                chk("mem_en", 64'(mem_en), 64'(exp_en));
                chk("done", 64'(done), 64'(exp_done));
                chk("rdata", 64'(rdata), 64'(hold));
                chk("stall", 64'(stall), 64'(req & ~exp_done));
            end
        end
    endtask

    // Each core in mask performs one access (core 0 performs 1+extra0), dropping
    // req for one cycle after each done before re-requesting.
    task automatic run_dir(input logic [NCORE-1:0] mask, input int extra0);
        int               remaining[NCORE];
        logic [NCORE-1:0] raise_next, dn, gn;
        int               busy_left;
        int               budget;
        raise_next = '0;
        for (int k = 0; k < NCORE; k++) remaining[k] = mask[k] ? 1 : 0;
        remaining[0] += mask[0] ? extra0 : 0;
        @(posedge clk); #1;
        req = mask;
        budget = 0;
        busy_left = 1;
        while (busy_left != 0 && budget < 200) begin
            budget++;
            @(negedge clk);
            dn = done;
            gn = gnt;
            @(posedge clk); #1;
            for (int k = 0; k < NCORE; k++) begin
                if (gn[k]) begin
                    addr[k*AW +: AW]  = AW'($urandom);
                    wdata[k*DW +: DW] = DW'($urandom);
                end
                if (dn[k] && remaining[k] > 0) begin
                    remaining[k]--;
                    req[k] = 1'b0;
                    raise_next[k] = (remaining[k] > 0);
                end else if (raise_next[k]) begin
                    req[k] = 1'b1;
                    raise_next[k] = 1'b0;
                end
            end
            busy_left = 0;
            for (int k = 0; k < NCORE; k++) busy_left += remaining[k];
        end
        chk("dir_timeout", 64'(busy_left), 64'd0);
        req = '0;
    endtask

    task automatic agent(input int k, input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            @(posedge clk); #1;
            we[k]             = 1'($urandom);
            addr[k*AW +: AW]  = AW'($urandom);
            wdata[k*DW +: DW] = DW'($urandom);
            req[k]            = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                if (done[k]) begin
                    got = 1'b1;
                end else if (gnt[k]) begin
                    @(posedge clk); #1;
                    addr[k*AW +: AW]  = AW'($urandom);
                    wdata[k*DW +: DW] = DW'($urandom);
                    if ($urandom_range(0, 9) == 0) req[k] = 1'b0;
                end
            end
            chk("agent_timeout", 64'(got), 64'd1);
            @(posedge clk); #1;
            req[k] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        fork
            model_and_monitor();
            begin
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                chk_en = 1'b1;
                @(negedge clk);
                chk("rst_gnt", 64'(gnt), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_mem_en", 64'(mem_en), 64'd0);
                chk("rst_mem_we", 64'(mem_we), 64'd0);
                chk("rst_rdata", 64'(rdata), 64'd0);
                chk("rst_mem_addr", 64'(mem_addr), 64'd0);
                chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);

                we[0] = 1'b0; addr[0 +: AW] = AW'(32'h10);
                run_dir(NCORE'(1), 0);
                chk("load_rdata", 64'(rdata), 64'h0000CAFE);

                we = '0; addr[0 +: AW] = AW'(32'h40); addr[AW +: AW] = AW'(32'h44);
                run_dir('1, 0);
                run_dir('1, 1);

                we[1] = 1'b1; addr[AW +: AW] = AW'(32'h20); wdata[DW +: DW] = DW'(32'h55);
                run_dir(NCORE'(2), 0);

                @(posedge clk); #1;
                we[0] = 1'b0; addr[0 +: AW] = AW'(32'h30); req = NCORE'(1);
                @(posedge clk); #1;
                rst = 1'b1; req = '0;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("abort_gnt", 64'(gnt), 64'd0);
                chk("abort_done", 64'(done), 64'd0);
                run_dir('1, 0);

                fork
                    agent(0, 80);
                    agent(1, 80);
                join
                repeat (6) @(posedge clk);
                chk("drain", 64'(q.size()), 64'd0);
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
